// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
//   op_e    : operation encodings carried on the op port
//   state_e : sequencer states (IDLE -> CALC -> FIX -> IDLE)
//   WIDTH_DEF : default operand / HI / LO width
package mul_div_unit_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/mul_div_unit_core.sv
// Datapath of the multiply/divide unit.
//   clk, reset     : clock, async active-high reset
//   load           : latch operand magnitudes / signs, clear accumulator
//   step           : perform one shift-add (mul) or restoring (div) iteration
//   op, in1, in2   : operation and operands, used only on load
//   res_hi, res_lo : sign-corrected result, meaningful after WIDTH steps
module mdu_core
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  // acc holds the product for multiply, or {remainder, quotient} for divide.
  // Both start as {0, |in1|}, so a single load path serves both.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   dividend_raw;
  logic               is_div;
  logic               neg_main;  // product / quotient must be negated
  logic               neg_rem;   // remainder must be negated (dividend sign)
  logic               div_zero;

  logic               op_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a_in;
  logic [WIDTH-1:0]   mag_b_in;

  always_comb begin
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = op_signed & in1[WIDTH-1];
    b_neg     = op_signed & in2[WIDTH-1];
    mag_a_in  = a_neg ? -in1 : in1;
    mag_b_in  = b_neg ? -in2 : in2;
  end

  // Shift-add multiply: add multiplicand into the upper half when the
  // current LSB is set, then shift the whole product right by one.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  // Restoring divide: shift in the next dividend bit, trial subtract,
  // keep the difference only if it did not borrow.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_b : '0)};
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
    if (div_diff[WIDTH+1]) begin
      div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc          <= '0;
      mag_b        <= '0;
      dividend_raw <= '0;
      is_div       <= 1'b0;
      neg_main     <= 1'b0;
      neg_rem      <= 1'b0;
      div_zero     <= 1'b0;
    end else if (load) begin
      acc          <= {{WIDTH{1'b0}}, mag_a_in};
      mag_b        <= mag_b_in;
      dividend_raw <= in1;
      is_div       <= (op == OP_DIV) || (op == OP_DIVU);
      neg_main     <= a_neg ^ b_neg;
      neg_rem      <= a_neg;
      div_zero     <= (in2 == '0);
    end else if (step) begin
      acc <= is_div ? div_next : mul_next;
    end
  end

  logic [2*WIDTH-1:0] prod_fix;

  always_comb begin
    prod_fix = neg_main ? -acc : acc;
    if (!is_div) begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end else if (div_zero) begin
      // Divide by zero returns the untouched dividend and an all-ones quotient.
      res_hi = dividend_raw;
      res_lo = '1;
    end else begin
      res_hi = neg_rem  ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      res_lo = neg_main ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
//   clk, reset   : clock, async active-high reset
//   start, op    : launch MULT/MULTU/DIV/DIVU; sampled only when idle
//   in1, in2     : operands (in1 also MTHI/MTLO data)
//   hi_we, lo_we : MTHI / MTLO, honoured only when idle
//   hi, lo       : architectural HI/LO
//   busy         : operation in flight (issue must stall)
//   done         : one-cycle pulse after HI/LO were written by mul/div
// Handshake: start is accepted on any edge where busy=0; the result is
// visible on hi/lo in the cycle where done=1, which never overlaps busy.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  state_e           state;
  state_e           next_state;
  logic [CNT_W-1:0] counter;
  logic             load;
  logic             step;
  logic             fix;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    fix        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (counter == CNT_W'(WIDTH - 1)) next_state = FIX;
      end
      FIX: begin
        fix        = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     counter <= '0;
    else if (load) counter <= '0;
    else if (step) counter <= counter + 1'b1;
  end

  // MT writes are only honoured while idle; a result from FIX always wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= fix;
      if (fix) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (state == IDLE) begin
        if (hi_we) hi <= in1;
        if (lo_we) lo <= in1;
      end
    end
  end

  assign busy = (state != IDLE);

  mdu_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .op     (op),
    .in1    (in1),
    .in2    (in2),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  in1;
  logic [W-1:0]  in2;
  logic          hi_we;
  logic          lo_we;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .in1   (in1),
    .in2   (in2),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Result as {hi, lo} computed directly with wide arithmetic.
  function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0]        ua, ub, r;
    sa = {{32{a[W-1]}}, a};
    sb = {{32{b[W-1]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    case (o)
      2'b00: r = sa * sb;
      2'b01: r = ua * ub;
      default: begin
        if (b == '0) begin
          r = {a, {W{1'b1}}};
        end else if (o == 2'b10) begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {sr[W-1:0], sq[W-1:0]};
        end else begin
          r = {ua[W-1:0] % ub[W-1:0], ua[W-1:0] / ub[W-1:0]};
        end
      end
    endcase
    return r;
  endfunction

  logic [W-1:0]   exp_hi, exp_lo;
  logic           exp_done;
  int             remaining;
  logic [2*W-1:0] pending;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_hi    <= '0;
      exp_lo    <= '0;
      exp_done  <= 1'b0;
      remaining <= 0;
      pending   <= '0;
    end else begin
      exp_done <= 1'b0;
      if (remaining > 0) begin
        remaining <= remaining - 1;
        if (remaining == 1) begin
          exp_hi   <= pending[2*W-1:W];
          exp_lo   <= pending[W-1:0];
          exp_done <= 1'b1;
        end
      end else begin
        if (hi_we) exp_hi <= in1;
        if (lo_we) exp_lo <= in1;
        if (start) begin
          pending   <= model(op, in1, in2);
          remaining <= LAT;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("cyc_hi", hi, exp_hi);
    chk("cyc_lo", lo, exp_lo);
    chk("cyc_busy", W'(busy), W'(remaining != 0));
    chk("cyc_done", W'(done), W'(exp_done));
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(output int busy_n, output int n);
    busy_n = 0;
    n      = 0;
    while (!done && n < 60) begin
      if (busy) busy_n++;
      @(negedge clk);
      in1 = $urandom;
      in2 = $urandom;
      n++;
    end
    chk("timeout", W'(n < 60), W'(1));
  endtask

  task automatic do_op(input string nm, input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    int busy_n, n;
    @(negedge clk);
    start = 1'b1; op = o; in1 = a; in2 = b;
    @(negedge clk);
    start = 1'b0; in1 = $urandom; in2 = $urandom;
    wait_done(busy_n, n);
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
    chk({nm, "_busy_cycles"}, W'(busy_n), W'(LAT));
    @(negedge clk);
    chk({nm, "_done_once"}, W'(done), W'(0));
    in1 = '0; in2 = '0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int busy_n, n;
    reset = 1'b1; start = 1'b0; op = 2'b00; in1 = '0; in2 = '0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    reset = 1'b0;

    do_op("mult_neg3x7",   2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    do_op("multu_max",     2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    do_op("mult_neg5neg6", 2'b00, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h0,        32'd30);
    do_op("div_neg7by2",   2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op("div_7byneg2",   2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
    do_op("divu_100by7",   2'b11, 32'd100,      32'd7,        32'd2,        32'd14);
    do_op("divu_by0",      2'b11, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF);
    do_op("div_neg_by0",   2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
    do_op("div_ovf",       2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000);

    // MTHI while idle
    @(negedge clk);
    hi_we = 1'b1; in1 = 32'h5555AAAA;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi", hi, 32'h5555AAAA);

    // start and MT writes ignored while busy
    @(negedge clk);
    start = 1'b1; op = 2'b01; in1 = 32'd5; in2 = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    start = 1'b1; op = 2'b10; in1 = 32'h1234; in2 = 32'd3; hi_we = 1'b1;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    wait_done(busy_n, n);
    chk("ign_hi", hi, 32'h0);
    chk("ign_lo", lo, 32'd30);
    @(negedge clk);
    chk("ign_no_restart", W'(busy), W'(0));

    // reset aborts an in-flight multiply, then MTLO
    start = 1'b1; op = 2'b00; in1 = 32'd3; in2 = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    chk("abort_busy", W'(busy), W'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    lo_we = 1'b1; in1 = 32'hABCD;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_lo", lo, 32'hABCD);
    chk("mtlo_done", W'(done), W'(0));
    repeat (40) @(negedge clk);
    chk("abort_no_late_done", lo, 32'hABCD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
